// File: rtl/bist_controller_if.sv
// Port bundle between the test-access/config side (master) and bist_controller (slave).
// irq/irq_clr exist only when BIST_DONE_IRQ_EN is defined.
interface bist_controller_if #(
  parameter int CNT_W = 8,
  parameter int SIG_W = 8
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] seed;
  logic [SIG_W-1:0] misr_init;
  logic [CNT_W-1:0] num_patterns;
  logic [SIG_W-1:0] golden_sig;
  logic [SIG_W-1:0] signature_in;
  logic [SIG_W-1:0] load_seed;
  logic [SIG_W-1:0] load_val;
  logic             load_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [SIG_W-1:0] sig_captured;
`ifdef BIST_DONE_IRQ_EN
  logic             irq_clr;
  logic             irq;
`endif

  modport slave (
`ifdef BIST_DONE_IRQ_EN
    input  irq_clr,
    output irq,
`endif
    input  start, abort, seed, misr_init, num_patterns, golden_sig, signature_in,
    output load_seed, load_val, load_en, busy, done, pass, fail, sig_captured
  );

  modport master (
`ifdef BIST_DONE_IRQ_EN
    output irq_clr,
    input  irq,
`endif
    output start, abort, seed, misr_init, num_patterns, golden_sig, signature_in,
    input  load_seed, load_val, load_en, busy, done, pass, fail, sig_captured
  );
endinterface

// File: rtl/bist_controller.sv
// Moore sequencer for the LFSR/MISR BIST datapath: load, run N patterns, check signature.
// Optional done interrupt (irq/irq_clr) enabled by defining BIST_DONE_IRQ_EN.
module bist_controller #(
  parameter int CNT_W = 8,
  parameter int SIG_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  bist_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             accept_s;
  logic             capture_s;
  logic [CNT_W-1:0] cnt_r;
  logic [SIG_W-1:0] seed_r;
  logic [SIG_W-1:0] init_r;
  logic [SIG_W-1:0] golden_r;
  logic [SIG_W-1:0] sig_cap_r;
  logic             pass_r;
  logic             fail_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode plus accept/capture strobes; abort outranks every other event.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_next_s = LOAD;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_next_s = IDLE;
        end else if (cnt_r != '0) begin
          state_next_s = RUN;
        end else begin
          state_next_s = CHECK;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next_s = IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = RUN;
        end
      end
      CHECK: begin
        if (bus.abort) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
          capture_s    = 1'b1;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Run configuration, pattern counter and sticky result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      seed_r    <= '0;
      init_r    <= '0;
      golden_r  <= '0;
      sig_cap_r <= '0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
    end else if (accept_s) begin
      cnt_r    <= bus.num_patterns;
      seed_r   <= bus.seed;
      init_r   <= bus.misr_init;
      golden_r <= bus.golden_sig;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
    end else if (capture_s) begin
      sig_cap_r <= bus.signature_in;
      pass_r    <= (bus.signature_in == golden_r);
      fail_r    <= (bus.signature_in != golden_r);
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Status decodes straight from the state register so reset clears them asynchronously.
  assign bus.load_en      = (state_r == LOAD);
  assign bus.busy         = (state_r == LOAD) || (state_r == RUN) || (state_r == CHECK);
  assign bus.done         = (state_r == DONE);
  assign bus.pass         = pass_r;
  assign bus.fail         = fail_r;
  assign bus.load_seed    = seed_r;
  assign bus.load_val     = init_r;
  assign bus.sig_captured = sig_cap_r;

`ifdef BIST_DONE_IRQ_EN
  logic irq_r;

  // Done interrupt: set leaving DONE (set beats clear), held until irq_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else if (state_r == DONE) begin
      irq_r <= 1'b1;
    end else if (bus.irq_clr) begin
      irq_r <= 1'b0;
    end
  end

  assign bus.irq = irq_r;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: directed table, hand sequences and random runs
// checked against a cycle-arithmetic model of the run timeline.
module tb_bist_controller;
  localparam int CNT_W = 8;
  localparam int SIG_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bist_controller_if #(.CNT_W(CNT_W), .SIG_W(SIG_W)) bus ();

  bist_controller #(.CNT_W(CNT_W), .SIG_W(SIG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] seed;
    logic [7:0] init;
    logic [7:0] golden;
    logic [7:0] sig;
    int         n;
    int         abort_at;
    int         restart_at;
    int         exp_done;
    bit         exp_pass;
    bit         exp_fail;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_cap = 8'h00;
  vec_t       tbl[8];

  function automatic vec_t mk(input logic [7:0] s, input logic [7:0] i, input logic [7:0] g,
                              input logic [7:0] sg, input int n, input int ab, input int rs,
                              input int dn, input bit p, input bit f);
    vec_t v;
    v.seed = s; v.init = i; v.golden = g; v.sig = sg; v.n = n;
    v.abort_at = ab; v.restart_at = rs; v.exp_done = dn; v.exp_pass = p; v.exp_fail = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle k counts from the cycle after the edge that accepts start (k=1 is LOAD).
  task automatic run_vec(input vec_t v, input string tag);
    logic [4:0] exp_v;
    logic [4:0] act_v;
    bit         live;
    @(negedge clk);
    bus.seed = v.seed; bus.misr_init = v.init; bus.num_patterns = 8'(v.n);
    bus.golden_sig = v.golden; bus.signature_in = v.sig; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.seed = ~v.seed; bus.misr_init = ~v.init; bus.num_patterns = 8'($urandom);
    bus.golden_sig = ~v.golden;
    for (int k = 1; k <= v.n + 5; k++) begin
      live  = (v.abort_at == 0) || (k <= v.abort_at);
      exp_v = {live && (k == 1), live && (k <= v.n + 2), (k == v.exp_done),
               v.exp_pass && (k >= v.n + 3), v.exp_fail && (k >= v.n + 3)};
      act_v = {bus.load_en, bus.busy, bus.done, bus.pass, bus.fail};
      check($sformatf("%s cyc%0d {load_en,busy,done,pass,fail}", tag, k), 32'(act_v), 32'(exp_v));
      bus.abort = (k == v.abort_at);
      bus.start = (k == v.restart_at);
      @(negedge clk);
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    if (v.exp_done != 0) exp_cap = v.sig;
    check({tag, " sig_captured"}, 32'(bus.sig_captured), 32'(exp_cap));
    check({tag, " load_seed"}, 32'(bus.load_seed), 32'(v.seed));
    check({tag, " load_val"}, 32'(bus.load_val), 32'(v.init));
  endtask

  task automatic reset_mid(input int at);
    @(negedge clk);
    bus.seed = 8'hC3; bus.misr_init = 8'h3C; bus.num_patterns = 8'd30;
    bus.golden_sig = 8'h00; bus.signature_in = 8'h00; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < at; k++) @(negedge clk);
    check($sformatf("pre_rst%0d {load_en,busy}", at), 32'({bus.load_en, bus.busy}),
          32'({at == 1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check($sformatf("in_rst%0d {load_en,busy,done,pass,fail}", at),
          32'({bus.load_en, bus.busy, bus.done, bus.pass, bus.fail}), 32'd0);
    check($sformatf("in_rst%0d regs", at),
          32'({bus.sig_captured, bus.load_seed, bus.load_val}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cap = 8'h00;
    @(negedge clk);
    check($sformatf("post_rst%0d busy", at), 32'({bus.load_en, bus.busy}), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   sel;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.seed = 8'h00; bus.misr_init = 8'h00;
    bus.num_patterns = 8'h00; bus.golden_sig = 8'h00; bus.signature_in = 8'h00;
`ifdef BIST_DONE_IRQ_EN
    bus.irq_clr = 1'b0;
`endif
    //         seed   init   golden sig    n    ab rs   done pass fail
    tbl[0] = mk(8'hA5, 8'h00, 8'h3C, 8'h3C, 10,  0, 0,  13,  1'b1, 1'b0);
    tbl[1] = mk(8'hA5, 8'h00, 8'h3C, 8'h3D, 10,  0, 0,  13,  1'b0, 1'b1);
    tbl[2] = mk(8'h11, 8'h5A, 8'h5A, 8'h5A, 0,   0, 0,  3,   1'b1, 1'b0);
    tbl[3] = mk(8'h77, 8'h12, 8'h99, 8'h99, 255, 0, 50, 258, 1'b1, 1'b0);
    tbl[4] = mk(8'h21, 8'h43, 8'h65, 8'h66, 20,  8, 0,  0,   1'b0, 1'b0);
    tbl[5] = mk(8'h01, 8'h02, 8'h40, 8'h40, 5,   0, 0,  8,   1'b1, 1'b0);
    tbl[6] = mk(8'hF0, 8'h0F, 8'hAA, 8'hAA, 3,   5, 0,  0,   1'b0, 1'b0);
    tbl[7] = mk(8'hE7, 8'h7E, 8'h01, 8'h02, 1,   0, 4,  4,   1'b0, 1'b1);

    repeat (2) @(negedge clk);
    check("reset {load_en,busy,done,pass,fail}",
          32'({bus.load_en, bus.busy, bus.done, bus.pass, bus.fail}), 32'd0);
    check("reset regs", 32'({bus.sig_captured, bus.load_seed, bus.load_val}), 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

    // start together with abort in IDLE must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start+abort cyc1", 32'({bus.load_en, bus.busy}), 32'd0);
    @(negedge clk);
    check("start+abort cyc2", 32'({bus.load_en, bus.busy}), 32'd0);

    reset_mid(1);
    reset_mid(10);
    run_vec(tbl[0], "after_rst");

    for (int r = 0; r < 20; r++) begin
      v.n      = int'($urandom_range(0, 40));
      v.seed   = 8'($urandom);
      v.init   = 8'($urandom);
      v.golden = 8'($urandom);
      v.sig    = ($urandom_range(0, 1) == 1) ? v.golden : 8'($urandom);
      sel      = int'($urandom_range(0, 3));
      v.abort_at   = (sel == 0) ? int'($urandom_range(1, v.n + 2)) : 0;
      v.restart_at = (sel == 1) ? int'($urandom_range(1, v.n + 3)) : 0;
      v.exp_done   = (v.abort_at == 0) ? v.n + 3 : 0;
      v.exp_pass   = (v.abort_at == 0) && (v.sig == v.golden);
      v.exp_fail   = (v.abort_at == 0) && (v.sig != v.golden);
      run_vec(v, $sformatf("rnd%0d", r));
    end

`ifdef BIST_DONE_IRQ_EN
    @(negedge clk);
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
    check("irq cleared", 32'(bus.irq), 32'd0);
    run_vec(tbl[4], "irq_abort");
    check("irq after abort", 32'(bus.irq), 32'd0);
    run_vec(tbl[5], "irq_run");
    check("irq after done", 32'(bus.irq), 32'd1);
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
    check("irq after clr", 32'(bus.irq), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
